// File: rtl/game_state_keeper.sv
// Score, lives and IDLE/PLAY/HIT/OVER state machine downstream of the collision controller.
// Optional feature macro EXTRA_LIFE_EN: award one life per thousands crossing of the score.
module game_state_keeper #(
    parameter int unsigned INIT_LIVES    = 3,
    parameter int unsigned MAX_LIVES     = 7,
    parameter logic [7:0]  HART_POINTS   = 8'h10,
    parameter int unsigned INVULN_FRAMES = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start_game,
    input  logic        SingleHitPulse,
    input  logic        collision,
    input  logic        collision_Smiley_Hart,
    output logic [15:0] score_bcd,
    output logic [2:0]  lives,
    output logic        playing,
    output logic        invulnerable,
    output logic        blink,
    output logic        life_lost_pulse,
    output logic        game_over,
    output logic [1:0]  state_dbg
);
    localparam logic [2:0] INIT_L = (INIT_LIVES > MAX_LIVES) ? 3'(MAX_LIVES) : 3'(INIT_LIVES);
    localparam logic [7:0] INV_L  = 8'(INVULN_FRAMES);
`ifdef EXTRA_LIFE_EN
    localparam logic [2:0] MAX_L  = 3'(MAX_LIVES);
`endif

    typedef enum logic [1:0] {IDLE, PLAY, HIT, OVER} state_t;

    state_t      state, state_nx;
    logic [15:0] score_nx;
    logic [2:0]  lives_nx;
    logic [7:0]  inv_cnt, inv_cnt_nx;
    logic [2:0]  frame_cnt, frame_cnt_nx;
    logic        dmg_flag, dmg_flag_nx;
    logic        damage, bonus, deduct;
    logic [15:0] bcd_sum;
    logic        bcd_ovf;
`ifdef EXTRA_LIFE_EN
    logic        thou_carry;
`endif

    assign damage    = collision & ~collision_Smiley_Hart;
    assign bonus     = SingleHitPulse;
    assign deduct    = (state == PLAY) && damage && !dmg_flag;
    assign state_dbg = state;

    // Digit-serial BCD add of the two-digit point value; carry out of the top digit means saturate.
    always_comb begin : bcd_add
        logic [15:0] addend;
        logic [4:0]  digit;
        logic        carry;
        addend  = {8'h00, HART_POINTS};
        carry   = 1'b0;
        digit   = '0;
        bcd_sum = '0;
`ifdef EXTRA_LIFE_EN
        thou_carry = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef EXTRA_LIFE_EN
            if (i == 3) thou_carry = carry;
`endif
            digit = {1'b0, score_bcd[4*i +: 4]} + {1'b0, addend[4*i +: 4]} + {4'b0000, carry};
            carry = (digit > 5'd9);
            if (carry) digit = digit - 5'd10;
            bcd_sum[4*i +: 4] = digit[3:0];
        end
        bcd_ovf = carry;
    end

    always_comb begin
        state_nx     = state;
        score_nx     = score_bcd;
        lives_nx     = lives;
        inv_cnt_nx   = inv_cnt;
        frame_cnt_nx = frame_cnt;
        dmg_flag_nx  = dmg_flag;
        if (startOfFrame) begin
            frame_cnt_nx = frame_cnt + 3'd1;
            dmg_flag_nx  = 1'b0;
        end
        case (state)
            IDLE, OVER: begin
                if (start_game) begin
                    state_nx = PLAY;
                    score_nx = '0;
                    lives_nx = INIT_L;
                end
            end
            PLAY, HIT: begin
                if (bonus) score_nx = bcd_ovf ? 16'h9999 : bcd_sum;
                if (deduct) lives_nx = lives - 3'd1;
`ifdef EXTRA_LIFE_EN
                // Deduct first, then award, so a coincident pair nets to no change even at the cap.
                if (bonus && thou_carry && !bcd_ovf && (lives_nx < MAX_L)) lives_nx = lives_nx + 3'd1;
`endif
                if (deduct) begin
                    dmg_flag_nx = 1'b1;
                    if (lives_nx == 3'd0) begin
                        state_nx = OVER;
                    end else begin
                        state_nx     = HIT;
                        inv_cnt_nx   = INV_L;
                        frame_cnt_nx = 3'd0;
                    end
                end else if (state == HIT && startOfFrame) begin
                    inv_cnt_nx = inv_cnt - 8'd1;
                    if (inv_cnt == 8'd1) state_nx = PLAY;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state           <= IDLE;
            score_bcd       <= '0;
            lives           <= INIT_L;
            inv_cnt         <= '0;
            frame_cnt       <= '0;
            dmg_flag        <= 1'b0;
            playing         <= 1'b0;
            invulnerable    <= 1'b0;
            blink           <= 1'b0;
            life_lost_pulse <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            state           <= state_nx;
            score_bcd       <= score_nx;
            lives           <= lives_nx;
            inv_cnt         <= inv_cnt_nx;
            frame_cnt       <= frame_cnt_nx;
            dmg_flag        <= dmg_flag_nx;
            playing         <= (state_nx == PLAY) || (state_nx == HIT);
            invulnerable    <= (state_nx == HIT);
            blink           <= (state_nx == HIT) && frame_cnt_nx[2];
            life_lost_pulse <= deduct;
            game_over       <= (state_nx == OVER);
        end
    end
endmodule

// File: tb/tb_game_state_keeper.sv
// Directed bench for game_state_keeper: vector table plus multi-cycle sequences.
// Expected lives in the crossing sequence depend on EXTRA_LIFE_EN.
module tb_game_state_keeper;
  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        start_game;
  logic        SingleHitPulse;
  logic        collision;
  logic        collision_Smiley_Hart;
  logic [15:0] score_bcd;
  logic [2:0]  lives;
  logic        playing;
  logic        invulnerable;
  logic        blink;
  logic        life_lost_pulse;
  logic        game_over;
  logic [1:0]  state_dbg;

`ifdef EXTRA_LIFE_EN
  localparam bit XL = 1'b1;
`else
  localparam bit XL = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  game_state_keeper #(
    .INIT_LIVES(3), .MAX_LIVES(7), .HART_POINTS(8'h10), .INVULN_FRAMES(6)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .start_game(start_game),
    .SingleHitPulse(SingleHitPulse), .collision(collision),
    .collision_Smiley_Hart(collision_Smiley_Hart), .score_bcd(score_bcd), .lives(lives),
    .playing(playing), .invulnerable(invulnerable), .blink(blink),
    .life_lost_pulse(life_lost_pulse), .game_over(game_over), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks; input vector order {start_game, startOfFrame, SingleHitPulse, collision, collision_Smiley_Hart}
  task automatic drive(input logic [4:0] in);
    {start_game, startOfFrame, SingleHitPulse, collision, collision_Smiley_Hart} = in;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetN = 1'b1;
    drive(5'b00000);
    step();
    step();
    resetN = 1'b0;
  endtask

  task automatic bonus_n(input int n);
    for (int k = 0; k < n; k++) begin
      drive(5'b00100);
      step();
    end
    drive(5'b00000);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // vector table
  typedef struct {
    logic [4:0]  in;
    logic [15:0] score;
    logic [2:0]  lives;
    logic [4:0]  flags;   // {playing, invulnerable, blink, life_lost_pulse, game_over}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] in, input logic [15:0] sc, input logic [2:0] lv,
                     input logic [4:0] fl);
    vec_t v;
    v.in = in; v.score = sc; v.lives = lv; v.flags = fl;
    vecs.push_back(v);
  endtask

  initial begin
    int  lost_cnt, sof_hit;
    bit  seen_hit, done, sof_v, pre_hit;

    // flags: {play, inv, blink, lost, over}
    add(5'b00000, 16'h0000, 3'd3, 5'b00000);  // idle
    add(5'b00100, 16'h0000, 3'd3, 5'b00000);  // bonus ignored in IDLE
    add(5'b00010, 16'h0000, 3'd3, 5'b00000);  // damage ignored in IDLE
    add(5'b10000, 16'h0000, 3'd3, 5'b10000);  // start
    add(5'b00100, 16'h0010, 3'd3, 5'b10000);
    add(5'b00100, 16'h0020, 3'd3, 5'b10000);
    add(5'b00100, 16'h0030, 3'd3, 5'b10000);
    add(5'b00011, 16'h0030, 3'd3, 5'b10000);  // hart collision is not damage
    add(5'b01000, 16'h0030, 3'd3, 5'b10000);
    add(5'b10000, 16'h0030, 3'd3, 5'b10000);  // start ignored in PLAY
    add(5'b00110, 16'h0040, 3'd2, 5'b11010);  // bonus + damage same cycle
    add(5'b00010, 16'h0040, 3'd2, 5'b11000);  // damage ignored in HIT
    add(5'b00100, 16'h0050, 3'd2, 5'b11000);  // bonus scored in HIT
    add(5'b01000, 16'h0050, 3'd2, 5'b11000);  // frame 1
    add(5'b01000, 16'h0050, 3'd2, 5'b11000);
    add(5'b01000, 16'h0050, 3'd2, 5'b11000);
    add(5'b01000, 16'h0050, 3'd2, 5'b11100);  // frame 4: blink
    add(5'b01000, 16'h0050, 3'd2, 5'b11100);
    add(5'b01000, 16'h0050, 3'd2, 5'b10000);  // 6th frame: back to PLAY
    add(5'b00010, 16'h0050, 3'd1, 5'b11010);
    add(5'b01000, 16'h0050, 3'd1, 5'b11000);
    add(5'b01000, 16'h0050, 3'd1, 5'b11000);
    add(5'b01000, 16'h0050, 3'd1, 5'b11000);
    add(5'b01000, 16'h0050, 3'd1, 5'b11100);
    add(5'b01000, 16'h0050, 3'd1, 5'b11100);
    add(5'b01000, 16'h0050, 3'd1, 5'b10000);
    add(5'b00010, 16'h0050, 3'd0, 5'b00011);  // last life -> OVER
    add(5'b00100, 16'h0050, 3'd0, 5'b00001);  // bonus ignored in OVER
    add(5'b00010, 16'h0050, 3'd0, 5'b00001);
    add(5'b10000, 16'h0000, 3'd3, 5'b10000);  // restart reinitialises
    add(5'b00100, 16'h0010, 3'd3, 5'b10000);

    do_reset();
    check("reset.score", score_bcd, 16'h0000);
    check("reset.lives", 16'(lives), 16'd3);
    check("reset.flags", 16'({playing, invulnerable, blink, life_lost_pulse, game_over}), 16'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].in);
      step();
      check($sformatf("vec%0d.score", i), score_bcd, vecs[i].score);
      check($sformatf("vec%0d.lives", i), 16'(lives), 16'(vecs[i].lives));
      check($sformatf("vec%0d.playing", i), 16'(playing), 16'(vecs[i].flags[4]));
      check($sformatf("vec%0d.invulnerable", i), 16'(invulnerable), 16'(vecs[i].flags[3]));
      check($sformatf("vec%0d.blink", i), 16'(blink), 16'(vecs[i].flags[2]));
      check($sformatf("vec%0d.life_lost", i), 16'(life_lost_pulse), 16'(vecs[i].flags[1]));
      check($sformatf("vec%0d.game_over", i), 16'(game_over), 16'(vecs[i].flags[0]));
    end
    drive(5'b00000);

    // damage held through the whole invulnerable window: one deduction, HIT spans 6 frames
    do_reset();
    drive(5'b10000);
    step();
    lost_cnt = 0; sof_hit = 0; seen_hit = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      sof_v = (c % 10 == 9);
      drive({1'b0, sof_v, 1'b0, 1'b1, 1'b0});
      pre_hit = invulnerable;
      step();
      if (life_lost_pulse) lost_cnt++;
      if (pre_hit && sof_v) sof_hit++;
      if (invulnerable) seen_hit = 1;
      else if (seen_hit) done = 1;
    end
    check("hold.timeout", 16'(done), 16'd1);
    check("hold.lost_pulses", 16'(lost_cnt), 16'd1);
    check("hold.hit_frames", 16'(sof_hit), 16'd6);
    check("hold.lives", 16'(lives), 16'd2);
    check("hold.playing", 16'(playing), 16'd1);
    drive(5'b00010);
    step();
    check("hold.redamage_lives", 16'(lives), 16'd1);
    check("hold.redamage_pulse", 16'(life_lost_pulse), 16'd1);
    drive(5'b00000);

    // damage coinciding with startOfFrame is still counted
    do_reset();
    drive(5'b10000);
    step();
    drive(5'b01010);
    step();
    check("sof_dmg.lives", 16'(lives), 16'd2);
    check("sof_dmg.pulse", 16'(life_lost_pulse), 16'd1);
    check("sof_dmg.invulnerable", 16'(invulnerable), 16'd1);
    drive(5'b00000);
    step();
    check("sof_dmg.pulse_one_cycle", 16'(life_lost_pulse), 16'd0);

    // thousands crossing and saturation
    do_reset();
    drive(5'b10000);
    step();
    bonus_n(99);
    check("bcd.0990", score_bcd, 16'h0990);
    drive(5'b00010);
    step();
    check("cross.pre_lives", 16'(lives), 16'd2);
    bonus_n(1);
    check("cross.score", score_bcd, 16'h1000);
    check("cross.lives", 16'(lives), XL ? 16'd3 : 16'd2);
    bonus_n(899);
    check("sat.9990", score_bcd, 16'h9990);
    check("sat.lives_capped", 16'(lives), XL ? 16'd7 : 16'd2);
    bonus_n(1);
    check("sat.9999", score_bcd, 16'h9999);
    check("sat.lives_unchanged", 16'(lives), XL ? 16'd7 : 16'd2);
    bonus_n(1);
    check("sat.hold", score_bcd, 16'h9999);
    check("sat.still_hit", 16'(invulnerable), 16'd1);

    // reset mid-game overrides concurrent inputs
    do_reset();
    drive(5'b10000);
    step();
    bonus_n(1);
    check("mid.pre_score", score_bcd, 16'h0010);
    resetN = 1'b1;
    drive(5'b10110);
    step();
    check("mid.score", score_bcd, 16'h0000);
    check("mid.lives", 16'(lives), 16'd3);
    check("mid.playing", 16'(playing), 16'd0);
    resetN = 1'b0;
    drive(5'b00000);
    step();
    check("mid.idle_after", 16'(playing), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/game_state_keeper.md
# game_state_keeper

Game-state keeper sitting directly downstream of the collision game controller. Consumes its per-frame hit pulse and collision levels, keeps the BCD score and remaining lives, and runs the play/invulnerable/game-over state machine. Its outputs drive the score/lives number drawers and gate player motion in the top-level VGA design.

## Interface
Parameters:
- INIT_LIVES, 3: lives loaded on game start and on reset (1..MAX_LIVES)
- MAX_LIVES, 7: lives saturation value (≤7)
- HART_POINTS, 8'h10: BCD points added per hart hit (two BCD digits, 00..99)
- INVULN_FRAMES, 60: frames of invulnerability after losing a life (1..255)

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous, active-high reset (asserted = 1)
- startOfFrame  in  1  one-cycle pulse per video frame
- start_game  in  1  one-cycle pulse from key debouncer
- SingleHitPulse  in  1  one-cycle bonus pulse, at most one per frame
- collision  in  1  level: any collision this pixel
- collision_Smiley_Hart  in  1  level: smiley/hart collision this pixel
- score_bcd  out  16  four BCD digits, [15:12] = thousands
- lives  out  3  remaining lives
- playing  out  1  high in PLAY or HIT
- invulnerable  out  1  high in HIT
- blink  out  1  smiley blink enable during HIT
- life_lost_pulse  out  1  one-cycle pulse when a life is deducted
- game_over  out  1  high in OVER

## Operation
- damage = collision & ~collision_Smiley_Hart; bonus = SingleHitPulse.
- States: IDLE, PLAY, HIT, OVER.
- IDLE: outputs held. start_game → PLAY; score_bcd := 0, lives := INIT_LIVES.
- PLAY: the first damage cycle of a frame deducts one life and pulses life_lost_pulse. If the new lives value is 0 → OVER, else → HIT with inv_cnt := INVULN_FRAMES.
- HIT: damage ignored. inv_cnt decrements on each startOfFrame; on startOfFrame with inv_cnt == 1 → PLAY.
- OVER: score and lives frozen; bonus ignored. start_game → PLAY with reinit, as from IDLE.
- Damage gating: dmg_flag is set when a life is deducted and cleared on startOfFrame. If damage and startOfFrame occur in the same cycle, damage is counted and the flag stays set. At most one deduction per frame.
- Bonus is scored in PLAY and HIT only. Score = 4-digit BCD add of HART_POINTS with decimal carry, saturating at 16'h9999.
- Bonus and damage in the same cycle: both are applied in that cycle.
- start_game in PLAY/HIT is ignored.
- blink = frame_cnt[2] in HIT, 0 otherwise. frame_cnt is a 3-bit counter incremented on startOfFrame and cleared on entry to HIT.

## Timing
- Reset (resetN=1 at a clk edge): state IDLE, score_bcd=0, lives=INIT_LIVES, inv_cnt=0, dmg_flag=0, all 1-bit outputs 0.
- All outputs are registered. Every update is visible one clk after the causing input cycle.
- life_lost_pulse is high exactly one cycle, coincident with the lives update.
- Reset mid-game overrides all inputs in that cycle and returns to IDLE.
- HIT lasts exactly INVULN_FRAMES startOfFrame pulses.

## Configuration
- EXTRA_LIFE_EN defined: whenever a bonus increments the thousands digit (score crosses 1000, 2000, …, excluding saturation), lives += 1 in the same cycle, saturating at MAX_LIVES.
- If a bonus and a damage deduction coincide with a thousands crossing, lives is unchanged net.
- EXTRA_LIFE_EN undefined: lives only decrease during a game; no thousands-crossing logic.

## Test plan
- Reset, start_game pulse → PLAY, lives=3, score_bcd=16'h0000, playing=1.
- Three SingleHitPulse in PLAY with HART_POINTS=8'h10 → score_bcd=16'h0030. With score 16'h9995, one more bonus → 16'h9999 (saturated).
- Damage held high for a whole frame (1000 cycles) → lives 3→2 once, one life_lost_pulse, invulnerable=1. With INVULN_FRAMES=4, further damage ignored; PLAY re-entered on the 4th startOfFrame.
- Three separated damage events → lives=0, game_over=1, bonus ignored. start_game → lives=3, score=0, PLAY.
- Damage and SingleHitPulse in the same cycle → score +10 and lives −1, both visible next cycle.
- EXTRA_LIFE_EN, score 16'h0995, lives=2, bonus 8'h10 → score 16'h1005, lives=3. At lives=7, a crossing leaves lives=7.
